// File: rtl/game_score_ctrl_pkg.sv
// Shared game definitions: state encodings and default round timing.
// Renderers compare against the ST_* values rather than literal encodings.
package game_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_PLAY = 2'b01,
        ST_OVER = 2'b10
    } game_state_e;

    localparam int FRAMES_PER_SEC = 60;
    localparam int GAME_SECONDS   = 30;

    // Counter width for values 0..n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/game_score_ctrl_if.sv
// Game-flow bus: player/collision events in, state and HUD counters out.
interface game_score_ctrl_if;
    import game_pkg::*;

    logic       start_btn;
    logic       shot;
    logic       hit;
    logic       frame_tick;
    logic [1:0] state;
    logic [3:0] score;
    logic [6:0] time_left;
    logic [3:0] shots_left;
    logic       over_pulse;

    modport master (
        output start_btn, shot, hit, frame_tick,
        input  state, score, time_left, shots_left, over_pulse
    );

    modport slave (
        input  start_btn, shot, hit, frame_tick,
        output state, score, time_left, shots_left, over_pulse
    );

endinterface

// File: rtl/game_score_ctrl_rise_detect.sv
// One-bit rising-edge detector; a held level yields a single event.
module rise_detect (
    input  logic clk_d,
    input  logic rst,
    input  logic din,
    output logic rise
);

    logic din_q;

    always_ff @(posedge clk_d) begin
        if (rst) din_q <= 1'b0;
        else     din_q <= din;
    end

    assign rise = din & ~din_q;

endmodule

// File: rtl/game_score_ctrl.sv
// Game-flow controller: idle -> play -> over sequencing with a saturating
// score digit, per-second countdown, shot budget and post-shot grace window.
module game_score_ctrl
    import game_pkg::game_state_e, game_pkg::ST_IDLE, game_pkg::ST_PLAY,
           game_pkg::ST_OVER, game_pkg::cnt_width;
#(
    parameter int FRAMES_PER_SEC = game_pkg::FRAMES_PER_SEC,
    parameter int GAME_SECONDS   = game_pkg::GAME_SECONDS,
    parameter int SHOTS          = 15,
    parameter int MAX_SCORE      = 9,
    parameter int GRACE_FRAMES   = 30
) (
    input logic              clk_d,
    input logic              rst,
    game_score_ctrl_if.slave bus
);

    localparam int FRAME_W = cnt_width(FRAMES_PER_SEC);
    localparam int GRACE_W = cnt_width(GRACE_FRAMES + 1);

    localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(FRAMES_PER_SEC - 1);
    localparam logic [GRACE_W-1:0] GRACE_END  = GRACE_W'(GRACE_FRAMES);
    localparam logic [6:0]         TIME_INIT  = 7'(GAME_SECONDS);
    localparam logic [3:0]         SHOTS_INIT = 4'(SHOTS);
    localparam logic [3:0]         SCORE_MAX  = 4'(MAX_SCORE);

    game_state_e        state_q, state_n;
    logic [3:0]         score_q, score_n;
    logic [6:0]         time_q, time_n;
    logic [3:0]         shots_q, shots_n;
    logic [FRAME_W-1:0] frame_q, frame_n;
    logic [GRACE_W-1:0] grace_q, grace_n;
    logic               over_q, over_n;
    logic               start_rise;

    rise_detect u_start_rise (
        .clk_d (clk_d),
        .rst   (rst),
        .din   (bus.start_btn),
        .rise  (start_rise)
    );

    always_ff @(posedge clk_d) begin
        if (rst) begin
            state_q <= ST_IDLE;
            score_q <= '0;
            time_q  <= TIME_INIT;
            shots_q <= SHOTS_INIT;
            frame_q <= '0;
            grace_q <= '0;
            over_q  <= 1'b0;
        end else begin
            state_q <= state_n;
            score_q <= score_n;
            time_q  <= time_n;
            shots_q <= shots_n;
            frame_q <= frame_n;
            grace_q <= grace_n;
            over_q  <= over_n;
        end
    end

    always_comb begin
        state_n = state_q;
        score_n = score_q;
        time_n  = time_q;
        shots_n = shots_q;
        frame_n = frame_q;
        grace_n = grace_q;
        over_n  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_rise) begin
                    state_n = ST_PLAY;
                    score_n = '0;
                    time_n  = TIME_INIT;
                    shots_n = SHOTS_INIT;
                    frame_n = '0;
                    grace_n = '0;
                end
            end
            ST_PLAY: begin
                if (bus.hit && (score_q < SCORE_MAX))
                    score_n = score_q + 4'd1;
                if (bus.shot && (shots_q != 4'd0))
                    shots_n = shots_q - 4'd1;
                if (bus.frame_tick) begin
                    if (frame_q == FRAME_LAST) begin
                        frame_n = '0;
                        if (time_q != 7'd0)
                            time_n = time_q - 7'd1;
                    end else begin
                        frame_n = frame_q + FRAME_W'(1);
                    end
                    // Grace only runs once the budget was already spent before this cycle.
                    if ((shots_q == 4'd0) && (grace_q != GRACE_END))
                        grace_n = grace_q + GRACE_W'(1);
                end
                if ((score_n == SCORE_MAX) || (time_n == 7'd0) || (grace_n == GRACE_END)) begin
                    state_n = ST_OVER;
                    over_n  = 1'b1;
                end
            end
            ST_OVER: begin
                if (start_rise)
                    state_n = ST_IDLE;
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    assign bus.state      = state_q;
    assign bus.score      = score_q;
    assign bus.time_left  = time_q;
    assign bus.shots_left = shots_q;
    assign bus.over_pulse = over_q;

endmodule

// File: tb/tb_game_score_ctrl.sv
// Directed self-checking bench for game_score_ctrl with default parameters.
module tb_game_score_ctrl;
    import game_pkg::*;

    logic clk_d = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_pass   = 0;

    always #5 clk_d = ~clk_d;

    game_score_ctrl_if gif();

    game_score_ctrl dut (
        .clk_d (clk_d),
        .rst   (rst),
        .bus   (gif.slave)
    );

    task automatic cycle();
        @(posedge clk_d);
        #1;
    endtask

    task automatic clear_inputs();
        gif.start_btn  = 1'b0;
        gif.shot       = 1'b0;
        gif.hit        = 1'b0;
        gif.frame_tick = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        cycle();
        cycle();
        rst = 1'b0;
    endtask

    task automatic start_round();
        gif.start_btn = 1'b1;
        cycle();
        gif.start_btn = 1'b0;
        cycle();
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++; if (gif.state !== 2'b00) $display("FAIL reset_state got %0d want 0", gif.state); else n_pass++;
        n_checks++; if (gif.score !== 4'd0) $display("FAIL reset_score got %0d want 0", gif.score); else n_pass++;
        n_checks++; if (gif.time_left !== 7'd30) $display("FAIL reset_time got %0d want 30", gif.time_left); else n_pass++;
        n_checks++; if (gif.shots_left !== 4'd15) $display("FAIL reset_shots got %0d want 15", gif.shots_left); else n_pass++;
        n_checks++; if (gif.over_pulse !== 1'b0) $display("FAIL reset_over got %0d want 0", gif.over_pulse); else n_pass++;
    endtask

    task automatic test_start();
        logic [1:0] prev;
        int         trans;
        do_reset();
        trans = 0;
        prev  = gif.state;
        gif.start_btn = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cycle();
            if (gif.state !== prev) trans++;
            prev = gif.state;
        end
        gif.start_btn = 1'b0;
        cycle();
        n_checks++; if (trans !== 1) $display("FAIL start_transitions got %0d want 1", trans); else n_pass++;
        n_checks++; if (gif.state !== 2'b01) $display("FAIL start_state got %0d want 1", gif.state); else n_pass++;
        n_checks++; if (gif.score !== 4'd0) $display("FAIL start_score got %0d want 0", gif.score); else n_pass++;
        n_checks++; if (gif.time_left !== 7'd30) $display("FAIL start_time got %0d want 30", gif.time_left); else n_pass++;
        n_checks++; if (gif.shots_left !== 4'd15) $display("FAIL start_shots got %0d want 15", gif.shots_left); else n_pass++;
    endtask

    task automatic test_hits();
        do_reset();
        start_round();
        for (int i = 1; i <= 9; i++) begin
            gif.hit = 1'b1;
            cycle();
            gif.hit = 1'b0;
            n_checks++; if (gif.score !== 4'(i)) $display("FAIL hits_score[%0d] got %0d want %0d", i, gif.score, i); else n_pass++;
            n_checks++; if (gif.state !== ((i == 9) ? 2'b10 : 2'b01)) $display("FAIL hits_state[%0d] got %0d want %0d", i, gif.state, (i == 9) ? 2 : 1); else n_pass++;
            n_checks++; if (gif.over_pulse !== (i == 9)) $display("FAIL hits_over[%0d] got %0d want %0d", i, gif.over_pulse, (i == 9)); else n_pass++;
            if (i == 3) begin
                gif.start_btn = 1'b1;
                cycle();
                gif.start_btn = 1'b0;
                n_checks++; if (gif.state !== 2'b01) $display("FAIL start_in_play got %0d want 1", gif.state); else n_pass++;
            end
        end
        cycle();
        n_checks++; if (gif.over_pulse !== 1'b0) $display("FAIL hits_over_len got %0d want 0", gif.over_pulse); else n_pass++;
        n_checks++; if (gif.state !== 2'b10) $display("FAIL hits_over_hold got %0d want 2", gif.state); else n_pass++;
        gif.hit = 1'b1;
        cycle();
        gif.hit = 1'b0;
        n_checks++; if (gif.score !== 4'd9) $display("FAIL hits_saturate got %0d want 9", gif.score); else n_pass++;
    endtask

    task automatic test_timer();
        logic [6:0] exp_t;
        do_reset();
        start_round();
        gif.frame_tick = 1'b1;
        for (int k = 1; k <= 1800; k++) begin
            cycle();
            exp_t = 7'(30 - k / 60);
            n_checks++; if (gif.time_left !== exp_t) $display("FAIL timer_time[%0d] got %0d want %0d", k, gif.time_left, exp_t); else n_pass++;
            n_checks++; if (gif.state !== ((k == 1800) ? 2'b10 : 2'b01)) $display("FAIL timer_state[%0d] got %0d want %0d", k, gif.state, (k == 1800) ? 2 : 1); else n_pass++;
        end
        gif.frame_tick = 1'b0;
        n_checks++; if (gif.over_pulse !== 1'b1) $display("FAIL timer_over got %0d want 1", gif.over_pulse); else n_pass++;
        n_checks++; if (gif.score !== 4'd0) $display("FAIL timer_score got %0d want 0", gif.score); else n_pass++;
    endtask

    task automatic test_shots();
        do_reset();
        start_round();
        gif.shot = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            cycle();
            n_checks++; if (gif.shots_left !== 4'((i > 15) ? 0 : 15 - i)) $display("FAIL shots_left[%0d] got %0d want %0d", i, gif.shots_left, (i > 15) ? 0 : 15 - i); else n_pass++;
        end
        gif.shot = 1'b0;
        for (int k = 1; k <= 30; k++) begin
            gif.frame_tick = 1'b1;
            cycle();
            gif.frame_tick = 1'b0;
            n_checks++; if (gif.state !== ((k == 30) ? 2'b10 : 2'b01)) $display("FAIL grace_state[%0d] got %0d want %0d", k, gif.state, (k == 30) ? 2 : 1); else n_pass++;
            if (k == 10) begin
                gif.hit = 1'b1;
                cycle();
                gif.hit = 1'b0;
                n_checks++; if (gif.score !== 4'd1) $display("FAIL grace_hit_score got %0d want 1", gif.score); else n_pass++;
            end
        end
        n_checks++; if (gif.over_pulse !== 1'b1) $display("FAIL grace_over got %0d want 1", gif.over_pulse); else n_pass++;
        n_checks++; if (gif.time_left !== 7'd30) $display("FAIL grace_time got %0d want 30", gif.time_left); else n_pass++;
        n_checks++; if (gif.score !== 4'd1) $display("FAIL grace_score got %0d want 1", gif.score); else n_pass++;
    endtask

    task automatic test_same_cycle();
        do_reset();
        start_round();
        gif.frame_tick = 1'b1;
        repeat (1799) cycle();
        gif.frame_tick = 1'b0;
        n_checks++; if (gif.time_left !== 7'd1) $display("FAIL same_pre_time got %0d want 1", gif.time_left); else n_pass++;
        gif.hit = 1'b1; gif.shot = 1'b1; gif.frame_tick = 1'b1;
        cycle();
        clear_inputs();
        n_checks++; if (gif.score !== 4'd1) $display("FAIL same_score got %0d want 1", gif.score); else n_pass++;
        n_checks++; if (gif.shots_left !== 4'd14) $display("FAIL same_shots got %0d want 14", gif.shots_left); else n_pass++;
        n_checks++; if (gif.time_left !== 7'd0) $display("FAIL same_time got %0d want 0", gif.time_left); else n_pass++;
        n_checks++; if (gif.state !== 2'b10) $display("FAIL same_state got %0d want 2", gif.state); else n_pass++;
        n_checks++; if (gif.over_pulse !== 1'b1) $display("FAIL same_over got %0d want 1", gif.over_pulse); else n_pass++;
        // Events in OVER must not move anything.
        gif.hit = 1'b1; gif.shot = 1'b1; gif.frame_tick = 1'b1;
        cycle();
        clear_inputs();
        n_checks++; if (gif.score !== 4'd1) $display("FAIL over_hold_score got %0d want 1", gif.score); else n_pass++;
        n_checks++; if (gif.shots_left !== 4'd14) $display("FAIL over_hold_shots got %0d want 14", gif.shots_left); else n_pass++;
        n_checks++; if (gif.over_pulse !== 1'b0) $display("FAIL over_hold_pulse got %0d want 0", gif.over_pulse); else n_pass++;
        gif.start_btn = 1'b1;
        cycle();
        gif.start_btn = 1'b0;
        cycle();
        n_checks++; if (gif.state !== 2'b00) $display("FAIL over_to_idle got %0d want 0", gif.state); else n_pass++;
        n_checks++; if (gif.score !== 4'd1) $display("FAIL idle_score_held got %0d want 1", gif.score); else n_pass++;
        force dut.state_q = game_state_e'(2'b11);
        #1;
        release dut.state_q;
        n_checks++; if (gif.state !== 2'b11) $display("FAIL upset_forced got %0d want 3", gif.state); else n_pass++;
        cycle();
        n_checks++; if (gif.state !== 2'b00) $display("FAIL upset_recover got %0d want 0", gif.state); else n_pass++;
        n_checks++; if (gif.score !== 4'd1) $display("FAIL upset_score got %0d want 1", gif.score); else n_pass++;
        n_checks++; if (gif.time_left !== 7'd0) $display("FAIL upset_time got %0d want 0", gif.time_left); else n_pass++;
        n_checks++; if (gif.shots_left !== 4'd14) $display("FAIL upset_shots got %0d want 14", gif.shots_left); else n_pass++;
        start_round();
        n_checks++; if (gif.score !== 4'd0) $display("FAIL reload_score got %0d want 0", gif.score); else n_pass++;
        n_checks++; if (gif.time_left !== 7'd30) $display("FAIL reload_time got %0d want 30", gif.time_left); else n_pass++;
        n_checks++; if (gif.shots_left !== 4'd15) $display("FAIL reload_shots got %0d want 15", gif.shots_left); else n_pass++;
    endtask

    task automatic test_reset_mid();
        do_reset();
        start_round();
        gif.hit = 1'b1;
        repeat (4) cycle();
        gif.hit = 1'b0;
        gif.shot = 1'b1;
        gif.frame_tick = 1'b1;
        cycle();
        n_checks++; if (gif.score !== 4'd4) $display("FAIL mid_score got %0d want 4", gif.score); else n_pass++;
        rst = 1'b1;
        gif.hit = 1'b1;
        gif.start_btn = 1'b1;
        cycle();
        rst = 1'b0;
        clear_inputs();
        n_checks++; if (gif.state !== 2'b00) $display("FAIL mid_rst_state got %0d want 0", gif.state); else n_pass++;
        n_checks++; if (gif.score !== 4'd0) $display("FAIL mid_rst_score got %0d want 0", gif.score); else n_pass++;
        n_checks++; if (gif.time_left !== 7'd30) $display("FAIL mid_rst_time got %0d want 30", gif.time_left); else n_pass++;
        n_checks++; if (gif.shots_left !== 4'd15) $display("FAIL mid_rst_shots got %0d want 15", gif.shots_left); else n_pass++;
        n_checks++; if (gif.over_pulse !== 1'b0) $display("FAIL mid_rst_over got %0d want 0", gif.over_pulse); else n_pass++;
        cycle();
        n_checks++; if (gif.state !== 2'b00) $display("FAIL mid_rst_idle got %0d want 0", gif.state); else n_pass++;
    endtask

    initial begin
        rst = 1'b1;
        clear_inputs();
        test_reset();
        test_start();
        test_hits();
        test_timer();
        test_shots();
        test_same_cycle();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
